// File: rtl/add_pipe_approx.sv
// ============================================================================
// add_pipe_approx
// ----------------------------------------------------------------------------
// Pipelined unsigned adder of two WIDTH-bit operands. Each beat can use exact
// addition or the lower-part-OR approximation. Carry propagation is split into
// SEGMENTS registered slices of SW = WIDTH/SEGMENTS bits. The block also counts
// how many delivered approximate results differ from the exact sum, and keeps
// the largest absolute error it has delivered.
//
// Parameters
//   WIDTH       operand width; the sum is WIDTH+1 bits
//   SEGMENTS    number of carry slices (WIDTH % SEGMENTS == 0)
//   APPROX_LSB  upper limit on the number of approximated LSBs
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   a, b       operands
//   mode       0 = exact, 1 = approximate
//   k          requested number of approximated LSBs (used only when mode=1)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result (exact or approximate)
//   err_cnt    saturating count of delivered results with sum != exact
//   max_err    largest |exact - sum| delivered since reset or clear
//   clr_stats  synchronous clear of err_cnt and max_err
//
// Latency is SEGMENTS cycles after acceptance. All levels advance together
// whenever the output register is empty or is being drained.
// ============================================================================
module add_pipe_approx #(
  parameter int WIDTH      = 8,
  parameter int SEGMENTS   = 2,
  parameter int APPROX_LSB = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       mode,
  input  logic [$clog2(WIDTH+1)-1:0] k,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH:0]             sum,
  output logic [15:0]                err_cnt,
  output logic [WIDTH:0]             max_err,
  input  logic                       clr_stats
);

  localparam int KW = $clog2(WIDTH + 1);
  localparam int SW = WIDTH / SEGMENTS;
  localparam logic [KW-1:0] APPROX_CAP = KW'(APPROX_LSB);

  // --------------------------------------------------------------------------
  // Pipeline levels
  //   level 0        : captured beat (operands, approximation masks, exact sum)
  //   level j (1..S) : bits below j*SW of acc already hold result bits, bits
  //                    above still hold operand A. B and the masks ride along
  //                    unchanged, which gives the skew delay for the upper
  //                    slices.
  //   level S        : complete result; {carry, acc} is the sum.
  // --------------------------------------------------------------------------
  logic             valid_reg  [0:SEGMENTS];
  logic             valid_next [0:SEGMENTS];
  logic [WIDTH-1:0] acc_reg    [0:SEGMENTS];
  logic [WIDTH-1:0] acc_next   [0:SEGMENTS];
  logic [WIDTH:0]   exact_reg  [0:SEGMENTS];
  logic [WIDTH:0]   exact_next [0:SEGMENTS];
  logic             carry_reg  [1:SEGMENTS];
  logic             carry_next [1:SEGMENTS];
  logic [WIDTH-1:0] b_reg      [0:SEGMENTS-1];
  logic [WIDTH-1:0] b_next     [0:SEGMENTS-1];
  logic [WIDTH-1:0] m_reg      [0:SEGMENTS-1];
  logic [WIDTH-1:0] m_next     [0:SEGMENTS-1];
  logic [WIDTH-1:0] t_reg      [0:SEGMENTS-1];
  logic [WIDTH-1:0] t_next     [0:SEGMENTS-1];

  logic adv;

  // Everything shifts together; a stalled output freezes the whole pipe.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = valid_reg[SEGMENTS];
  assign sum       = {carry_reg[SEGMENTS], acc_reg[SEGMENTS]};

  // --------------------------------------------------------------------------
  // Input decode: effective depth and per-bit masks
  //   in_mask[i] : bit i is in the OR region (i < keff)
  //   in_top[i]  : bit i is the top OR bit (i == keff-1); its a&b becomes the
  //                carry into the exact region
  // --------------------------------------------------------------------------
  logic [KW-1:0]    keff;
  logic [WIDTH-1:0] in_mask;
  logic [WIDTH-1:0] in_top;

  always_comb begin
    keff = '0;
    if (mode) begin
      keff = (k > APPROX_CAP) ? APPROX_CAP : k;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign in_mask[gi] = (KW'(gi) < keff);
      assign in_top[gi]  = (KW'(gi + 1) == keff);
    end
  endgenerate

  assign valid_next[0] = in_valid;
  assign acc_next[0]   = a;
  assign b_next[0]     = b;
  assign m_next[0]     = in_mask;
  assign t_next[0]     = in_top;
  assign exact_next[0] = {1'b0, a} + {1'b0, b};

  // --------------------------------------------------------------------------
  // Carry slices: stage gi resolves bits [gi*SW +: SW] of level gi.
  // --------------------------------------------------------------------------
  generate
    for (gi = 0; gi < SEGMENTS; gi++) begin : g_stage
      logic             cin;
      logic [SW-1:0]    slice_sum;
      logic             slice_cout;
      logic [WIDTH-1:0] merged;

      if (gi == 0) begin : g_cin_zero
        assign cin = 1'b0;
      end else begin : g_cin_prev
        assign cin = carry_reg[gi];
      end

      always_comb begin
        logic c;
        logic ai;
        logic bi;
        c         = cin;
        ai        = 1'b0;
        bi        = 1'b0;
        slice_sum = '0;
        for (int i = 0; i < SW; i++) begin
          ai = acc_reg[gi][gi*SW + i];
          bi = b_reg[gi][gi*SW + i];
          if (m_reg[gi][gi*SW + i]) begin
            // OR region: no carry travels through it. Only the top bit of
            // the region launches a carry (its generate term).
            slice_sum[i] = ai | bi;
            c            = t_reg[gi][gi*SW + i] & ai & bi;
          end else begin
            slice_sum[i] = ai ^ bi ^ c;
            c            = (ai & bi) | (c & (ai ^ bi));
          end
        end
        slice_cout = c;
      end

      always_comb begin
        merged                 = acc_reg[gi];
        merged[gi*SW +: SW]    = slice_sum;
      end

      assign valid_next[gi+1] = valid_reg[gi];
      assign acc_next[gi+1]   = merged;
      assign carry_next[gi+1] = slice_cout;
      assign exact_next[gi+1] = exact_reg[gi];

      if (gi < SEGMENTS - 1) begin : g_fwd
        assign b_next[gi+1] = b_reg[gi];
        assign m_next[gi+1] = m_reg[gi];
        assign t_next[gi+1] = t_reg[gi];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Level registers. Reset drops every in-flight beat.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l <= SEGMENTS; l++) begin
        valid_reg[l] <= 1'b0;
        acc_reg[l]   <= '0;
        exact_reg[l] <= '0;
      end
      for (int l = 1; l <= SEGMENTS; l++) begin
        carry_reg[l] <= 1'b0;
      end
      for (int l = 0; l < SEGMENTS; l++) begin
        b_reg[l] <= '0;
        m_reg[l] <= '0;
        t_reg[l] <= '0;
      end
    end else if (adv) begin
      for (int l = 0; l <= SEGMENTS; l++) begin
        valid_reg[l] <= valid_next[l];
        acc_reg[l]   <= acc_next[l];
        exact_reg[l] <= exact_next[l];
      end
      for (int l = 1; l <= SEGMENTS; l++) begin
        carry_reg[l] <= carry_next[l];
      end
      for (int l = 0; l < SEGMENTS; l++) begin
        b_reg[l] <= b_next[l];
        m_reg[l] <= m_next[l];
        t_reg[l] <= t_next[l];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Error statistics, updated on delivered results only.
  // The approximation can land on either side of the exact sum (the top OR
  // bit may inject a carry the exact sum does not have), so the error is
  // taken as an absolute difference.
  // --------------------------------------------------------------------------
  logic           xfer;
  logic           mismatch;
  logic [WIDTH:0] abs_diff;

  assign xfer     = out_valid & out_ready;
  assign mismatch = (sum != exact_reg[SEGMENTS]);
  assign abs_diff = (exact_reg[SEGMENTS] >= sum) ? (exact_reg[SEGMENTS] - sum)
                                                 : (sum - exact_reg[SEGMENTS]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      max_err <= '0;
    end else if (clr_stats) begin
      // A clear outranks a transfer in the same cycle.
      err_cnt <= '0;
      max_err <= '0;
    end else if (xfer && mismatch) begin
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (abs_diff > max_err) begin
        max_err <= abs_diff;
      end
    end
  end

endmodule

// File: tb/tb_add_pipe_approx.sv
// ============================================================================
// tb_add_pipe_approx
// Directed bench for add_pipe_approx (WIDTH=8, SEGMENTS=2, APPROX_LSB=4).
// A table of hand-computed vectors is applied one beat at a time, followed by
// hand-written sequences for back-to-back beats, backpressure, statistics
// saturation/clear and reset while beats are in flight. A negedge monitor
// scores every delivered result against a bit-level reference model.
// ============================================================================
module tb_add_pipe_approx;

  localparam int WIDTH      = 8;
  localparam int SEGMENTS   = 2;
  localparam int APPROX_LSB = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  a         = '0;
  logic [7:0]  b         = '0;
  logic        mode      = 1'b0;
  logic [3:0]  k         = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [8:0]  sum;
  logic [15:0] err_cnt;
  logic [8:0]  max_err;
  logic        clr_stats = 1'b0;

  add_pipe_approx #(
    .WIDTH      (WIDTH),
    .SEGMENTS   (SEGMENTS),
    .APPROX_LSB (APPROX_LSB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .err_cnt   (err_cnt),
    .max_err   (max_err),
    .clr_stats (clr_stats)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_out  = 0;
  bit quiet  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else if (!quiet) begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Reference: OR the low keff bits, carry a[keff-1]&b[keff-1] into the rest.
  function automatic logic [8:0] model_sum(input logic [7:0] ma, input logic [7:0] mb,
                                           input logic mm, input logic [3:0] mk);
    int keff, ia, ib, lo, cin, up;
    ia   = int'(ma);
    ib   = int'(mb);
    keff = mm ? ((int'(mk) > APPROX_LSB) ? APPROX_LSB : int'(mk)) : 0;
    if (keff == 0) return 9'(ia + ib);
    lo  = (ia | ib) & ((1 << keff) - 1);
    cin = (ia >> (keff - 1)) & (ib >> (keff - 1)) & 1;
    up  = (ia >> keff) + (ib >> keff) + cin;
    return 9'((up << keff) | lo);
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard: inputs and outputs are stable around the negedge, so what is
  // seen here is what the next rising edge will act upon.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [8:0] s;
    logic [8:0] e;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [8:0]  mon_d;
  logic [15:0] m_err = '0;
  logic [8:0]  m_max = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL stream_extra_beat: got sum 0x%0h, required no beat", sum);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_sum", 32'(sum), 32'(mon_e.s));
          if (!clr_stats && (mon_e.s != mon_e.e)) begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            mon_d = (mon_e.e >= mon_e.s) ? (mon_e.e - mon_e.s) : (mon_e.s - mon_e.e);
            if (mon_d > m_max) m_max = mon_d;
          end
        end
      end
      if (clr_stats) begin
        m_err = '0;
        m_max = '0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{model_sum(a, b, mode, k), {1'b0, a} + {1'b0, b}});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat; returns the result and cycles from acceptance to
  // out_valid, then lets the transfer happen.
  task automatic run_one(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                         input logic [3:0] ik, output logic [8:0] got, output int lat);
    a = ia; b = ib; mode = im; k = ik; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    if (!out_valid) check("tmo_out_valid", 32'(out_valid), 32'd1);
    got = sum;
    cyc();
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        mode;
    logic [3:0]  k;
    logic [8:0]  s;
    logic [15:0] err;
    logic [8:0]  mx;
  } vec_t;

  vec_t       tbl[13];
  logic [8:0] got;
  int         lat;
  logic [7:0] ra[8];
  logic [7:0] rb[8];
  logic       rm[8];
  logic [3:0] rk[8];

  initial begin
    // Expected statistics accumulate from reset down the table.
    tbl[0]  = '{8'hFF, 8'h01, 1'b0, 4'd0, 9'h100, 16'd0, 9'd0};
    tbl[1]  = '{8'h0F, 8'h01, 1'b1, 4'd4, 9'h00F, 16'd1, 9'd1};
    tbl[2]  = '{8'h08, 8'h08, 1'b1, 4'd4, 9'h018, 16'd2, 9'd8};
    tbl[3]  = '{8'h0F, 8'h01, 1'b1, 4'd6, 9'h00F, 16'd3, 9'd8};
    tbl[4]  = '{8'h0F, 8'h01, 1'b0, 4'd4, 9'h010, 16'd3, 9'd8};
    tbl[5]  = '{8'h0F, 8'h01, 1'b1, 4'd0, 9'h010, 16'd3, 9'd8};
    tbl[6]  = '{8'hFF, 8'hFF, 1'b1, 4'd4, 9'h1FF, 16'd4, 9'd8};
    tbl[7]  = '{8'h55, 8'hAA, 1'b1, 4'd4, 9'h0FF, 16'd4, 9'd8};
    tbl[8]  = '{8'h03, 8'h01, 1'b1, 4'd2, 9'h003, 16'd5, 9'd8};
    tbl[9]  = '{8'h80, 8'h80, 1'b1, 4'd4, 9'h100, 16'd5, 9'd8};
    tbl[10] = '{8'h07, 8'h09, 1'b1, 4'd1, 9'h011, 16'd6, 9'd8};
    tbl[11] = '{8'h0C, 8'h0C, 1'b1, 4'd3, 9'h01C, 16'd7, 9'd8};
    tbl[12] = '{8'h07, 8'h07, 1'b1, 4'd4, 9'h007, 16'd8, 9'd8};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_max_err",   32'(max_err),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    cyc();

    // ---- table vectors ----
    for (int i = 0; i < 13; i++) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].k, got, lat);
      check("tbl_sum",     32'(got),     32'(tbl[i].s));
      check("tbl_latency", 32'(lat),     32'(SEGMENTS));
      check("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].err));
      check("tbl_max_err", 32'(max_err), 32'(tbl[i].mx));
    end

    // ---- clamp + per-beat mode, back to back ----
    a = 8'h0F; b = 8'h01; mode = 1'b1; k = 4'd6; in_valid = 1'b1;
    cyc();
    mode = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("b2b_valid0", 32'(out_valid), 32'd1);
    check("b2b_sum0",   32'(sum),       32'h00F);
    cyc();
    check("b2b_valid1", 32'(out_valid), 32'd1);
    check("b2b_sum1",   32'(sum),       32'h010);
    repeat (3) cyc();

    // ---- backpressure: 8 random beats, out_ready low on cycles 3..5 ----
    for (int i = 0; i < 8; i++) begin
      ra[i] = 8'($urandom);
      rb[i] = 8'($urandom);
      rm[i] = 1'($urandom);
      rk[i] = 4'($urandom_range(0, 15));
    end
    begin
      int  idx;
      int  c;
      int  start_out;
      bit  acc;
      idx       = 0;
      c         = 0;
      start_out = n_out;
      while ((n_out - start_out < 8) && c < 100) begin
        out_ready = !(c >= 3 && c <= 5);
        if (idx < 8) begin
          in_valid = 1'b1; a = ra[idx]; b = rb[idx]; mode = rm[idx]; k = rk[idx];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (!out_ready && out_valid) check("bp_in_ready_low", 32'(in_ready), 32'd0);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) idx++;
        c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_delivered",   32'(n_out - start_out), 32'd8);
      check("bp_queue_empty", 32'(exp_q.size()),      32'd0);
    end
    repeat (2) cyc();

    // ---- clear with no transfer ----
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_max_err", 32'(max_err), 32'd0);

    // ---- saturation: stream mismatching beats (diff 1) until 0xFFFF ----
    begin
      int guard;
      guard = 0;
      quiet = 1'b1;
      a = 8'h0F; b = 8'h01; mode = 1'b1; k = 4'd4; in_valid = 1'b1;
      while (m_err != 16'hFFFF && guard < 70000) begin
        cyc();
        guard++;
      end
      repeat (4) cyc();
      in_valid = 1'b0;
      repeat (4) cyc();
      quiet = 1'b0;
      check("sat_err_cnt", 32'(err_cnt), 32'h0000FFFF);
      check("sat_max_err", 32'(max_err), 32'd1);
    end

    // ---- clear in the same cycle as a mismatching transfer ----
    begin
      int w;
      a = 8'h08; b = 8'h08; mode = 1'b1; k = 4'd4; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin
        cyc();
        w++;
      end
      check("clrx_out_valid", 32'(out_valid), 32'd1);
      clr_stats = 1'b1;
      cyc();
      clr_stats = 1'b0;
      check("clrx_err_cnt", 32'(err_cnt), 32'd0);
      check("clrx_max_err", 32'(max_err), 32'd0);
    end

    // ---- reset with two beats in flight ----
    run_one(8'h0F, 8'h01, 1'b1, 4'd4, got, lat);
    check("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
    out_ready = 1'b0;
    a = 8'h0F; b = 8'h01; mode = 1'b1; k = 4'd4; in_valid = 1'b1;
    cyc();
    a = 8'h08; b = 8'h08;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum",       32'(sum),       32'd0);
    check("mid_rst_err_cnt",   32'(err_cnt),   32'd0);
    check("mid_rst_max_err",   32'(max_err),   32'd0);
    exp_q.delete();
    m_err = '0;
    m_max = '0;
    out_ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    run_one(8'h3E, 8'h0B, 1'b1, 4'd2, got, lat);
    check("post_rst_sum",     32'(got),     32'h04B);
    check("post_rst_latency", 32'(lat),     32'(SEGMENTS));
    check("post_rst_err_cnt", 32'(err_cnt), 32'd1);
    check("post_rst_max_err", 32'(max_err), 32'd2);
    repeat (3) cyc();
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
